// File: rtl/burp_fetch_unit_pkg.sv
// burp_fetch_unit_pkg: opcode values, instruction field positions and fetch state codes shared by the BURP fetch stage
package burp_fetch_unit_pkg;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JC  = 4'hF;
  localparam int OPC_W = 4;
  typedef enum logic [1:0] {FETCH, EXT, ISSUE, HALT} fetch_state_t;
  function automatic logic is_two_byte(input logic [OPC_W-1:0] op);
    return op == OP_JMP || op == OP_JC;
  endfunction
endpackage

// File: rtl/burp_fetch_unit_pc.sv
// burp_fetch_unit_pc: program counter with reset-to-RESET_PC, load and modulo-2^ADDR_W increment (ports: clk, reset, load, inc, load_addr, pc)
module burp_fetch_unit_pc #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    if (reset) pc <= RESET_PC;
    else if (load) pc <= load_addr;
    else if (inc) pc <= pc + ADDR_W'(1);
endmodule

// File: rtl/burp_fetch_unit.sv
// burp_fetch_unit: BURP fetch stage; drives rom_addr from the PC, assembles 1/2-byte instructions, resolves JMP locally, takes execute redirects, issues to decode via instr_valid/instr_ready; optional FETCH_HALT_ON_BLANK_EN halts on opcode byte 8'hFF (halted output)
module burp_fetch_unit
  import burp_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_opcode,
  output logic [3:0]        instr_operand,
  output logic [ADDR_W-1:0] instr_target,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);
  fetch_state_t state;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc, tgt, ipc, pc_next;
  logic pc_load, pc_inc, redir, blank;
`ifdef FETCH_HALT_ON_BLANK_EN
  assign blank = state == FETCH && rom_data == '1;
  assign halted = state == HALT;
`else
  assign blank = 1'b0;
  assign halted = 1'b0;
`endif
  // HALT is only left through reset, so redirects are dropped there
  assign redir = redirect_en && state != HALT;
  always_comb begin
    pc_load = redir || (state == EXT && ir[DATA_W-1 -: 4] == OP_JMP);
    pc_next = redir ? redirect_addr : ADDR_W'(rom_data);
    pc_inc = (state == FETCH && !blank) || state == EXT;
  end
  burp_fetch_unit_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .load(pc_load), .inc(pc_inc), .load_addr(pc_next), .pc(pc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      ir <= '0;
      tgt <= '0;
      ipc <= '0;
    end else if (redir) state <= FETCH;
    else
      case (state)
        FETCH: begin
          ir <= rom_data;
          ipc <= pc;
          tgt <= '0;
          state <= blank ? HALT : is_two_byte(rom_data[DATA_W-1 -: 4]) ? EXT : ISSUE;
        end
        EXT: begin
          tgt <= ADDR_W'(rom_data);
          state <= ir[DATA_W-1 -: 4] == OP_JMP ? FETCH : ISSUE;
        end
        ISSUE: state <= instr_ready ? FETCH : ISSUE;
        default: state <= state;
      endcase
  assign rom_addr = pc;
  assign instr_valid = state == ISSUE;
  assign instr_opcode = ir[DATA_W-1 -: 4];
  assign instr_operand = ir[3:0];
  assign instr_target = tgt;
  assign instr_pc = ipc;
endmodule

// File: tb/tb_burp_fetch_unit.sv
// tb_burp_fetch_unit: self-checking bench for burp_fetch_unit with directed scenarios and a random scoreboard
module tb_burp_fetch_unit;
  logic clk = 0, reset = 1, instr_ready = 0, redirect_en = 0;
  logic [7:0] redirect_addr = 0, rom_addr, rom_data, instr_target, instr_pc;
  logic instr_valid, halted;
  logic [3:0] instr_opcode, instr_operand;
  logic [7:0] rom [256];
  logic [23:0] obs;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [3:0] op; logic [3:0] opr; logic [7:0] tgt; logic [7:0] pc;} ins_t;
  ins_t q[$];
  logic [7:0] mpc;
  bit mhalt;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  assign obs = {instr_opcode, instr_operand, instr_target, instr_pc};

  burp_fetch_unit dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .instr_target(instr_target), .instr_pc(instr_pc),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halted(halted)
  );

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    redirect_en = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Walks the ROM image as a program listing: JMP folds into a jump, JC and others become queue entries
  task automatic refill();
    int steps = 0;
    while (q.size() < 8 && !mhalt && steps < 300) begin
      logic [7:0] b, nx;
      b = rom[mpc];
      nx = mpc + 8'd1;
      steps++;
`ifdef FETCH_HALT_ON_BLANK_EN
      if (b == 8'hFF) mhalt = 1;
      else
`endif
      if (b[7:4] == 4'hE) mpc = rom[nx];
      else if (b[7:4] == 4'hF) begin
        q.push_back({4'hF, b[3:0], rom[nx], mpc});
        mpc = mpc + 8'd2;
      end else begin
        q.push_back({b[7:4], b[3:0], 8'h00, mpc});
        mpc = nx;
      end
    end
  endtask

  task automatic test_reset();
    clear_rom();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got %h required %h", {instr_valid, obs}, 25'h0);
    end
    n_chk++;
    if ({rom_addr, halted} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_pc_halt: got %h required %h", {rom_addr, halted}, 9'h0);
    end
  endtask

  task automatic test_basic();
    clear_rom();
    rom[0] = 8'hCA;
    rom[1] = 8'hD4;
    instr_ready = 1;
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'hCA_00_00}) begin
      n_fail++;
      $display("FAIL basic_mvi: got %h required %h", {instr_valid, obs}, {1'b1, 24'hCA_00_00});
    end
    @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_gap: got %b required 0", instr_valid);
    end
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'hD4_00_01}) begin
      n_fail++;
      $display("FAIL basic_mov: got %h required %h", {instr_valid, obs}, {1'b1, 24'hD4_00_01});
    end
  endtask

  task automatic test_backpressure();
    clear_rom();
    rom[0] = 8'hCA;
    rom[1] = 8'hD4;
    instr_ready = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({instr_valid, obs, rom_addr} !== {1'b1, 24'hCA_00_00, 8'h01}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h required %h", i, {instr_valid, obs, rom_addr}, {1'b1, 24'hCA_00_00, 8'h01});
      end
    end
    instr_ready = 1;
    @(negedge clk);
    n_chk++;
    if ({instr_valid, rom_addr} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL bp_accept: got %h required %h", {instr_valid, rom_addr}, {1'b0, 8'h01});
    end
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'hD4_00_01}) begin
      n_fail++;
      $display("FAIL bp_next: got %h required %h", {instr_valid, obs}, {1'b1, 24'hD4_00_01});
    end
  endtask

  task automatic test_jmp();
    clear_rom();
    rom[0] = 8'hE0;
    rom[1] = 8'h20;
    rom[2] = 8'h55;
    instr_ready = 1;
    do_reset();
    @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jmp_noissue1: got %b required 0", instr_valid);
    end
    @(negedge clk);
    n_chk++;
    if ({instr_valid, rom_addr} !== {1'b0, 8'h20}) begin
      n_fail++;
      $display("FAIL jmp_noissue2: got %h required %h", {instr_valid, rom_addr}, {1'b0, 8'h20});
    end
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'h00_00_20}) begin
      n_fail++;
      $display("FAIL jmp_target: got %h required %h", {instr_valid, obs}, {1'b1, 24'h00_00_20});
    end
  endtask

  task automatic test_jc_redirect();
    clear_rom();
    rom[0] = 8'hF0;
    rom[1] = 8'h40;
    rom[2] = 8'h11;
    rom[8'h40] = 8'h57;
    instr_ready = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'hF0_40_00}) begin
      n_fail++;
      $display("FAIL jc_issue: got %h required %h", {instr_valid, obs}, {1'b1, 24'hF0_40_00});
    end
    @(negedge clk);
    redirect_en = 1;
    redirect_addr = 8'h40;
    @(negedge clk);
    redirect_en = 0;
    n_chk++;
    if ({instr_valid, rom_addr} !== {1'b0, 8'h40}) begin
      n_fail++;
      $display("FAIL jc_redirect_pc: got %h required %h", {instr_valid, rom_addr}, {1'b0, 8'h40});
    end
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'h57_00_40}) begin
      n_fail++;
      $display("FAIL jc_redirect_next: got %h required %h", {instr_valid, obs}, {1'b1, 24'h57_00_40});
    end
  endtask

  task automatic test_wrap_reset();
    clear_rom();
    rom[8'hFE] = 8'hF0;
    rom[8'hFF] = 8'h33;
    rom[0] = 8'h12;
    instr_ready = 1;
    do_reset();
    redirect_en = 1;
    redirect_addr = 8'hFE;
    @(negedge clk);
    redirect_en = 0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs, rom_addr} !== {1'b1, 24'hF0_33_FE, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap_jc: got %h required %h", {instr_valid, obs, rom_addr}, {1'b1, 24'hF0_33_FE, 8'h00});
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== {1'b1, 24'h12_00_00}) begin
      n_fail++;
      $display("FAIL wrap_next: got %h required %h", {instr_valid, obs}, {1'b1, 24'h12_00_00});
    end
    redirect_en = 1;
    @(negedge clk);
    redirect_en = 0;
    @(negedge clk);
    n_chk++;
    if ({instr_valid, rom_addr} !== {1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL wrap_in_ext: got %h required %h", {instr_valid, rom_addr}, {1'b0, 8'hFF});
    end
    reset = 1;
    @(negedge clk);
    n_chk++;
    if ({instr_valid, rom_addr} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_ext: got %h required %h", {instr_valid, rom_addr}, {1'b0, 8'h00});
    end
    @(negedge clk);
    n_chk++;
    if ({instr_valid, obs} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_mid_ext_hold: got %h required %h", {instr_valid, obs}, 25'h0);
    end
    reset = 0;
  endtask

  task automatic test_blank();
    clear_rom();
    rom[0] = 8'hFF;
    rom[1] = 8'h40;
    instr_ready = 1;
    do_reset();
`ifdef FETCH_HALT_ON_BLANK_EN
    for (int i = 0; i < 4; i++) begin
      redirect_en = i == 1;
      redirect_addr = 8'h55;
      @(negedge clk);
      n_chk++;
      if ({halted, instr_valid, rom_addr} !== {1'b1, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL halt%0d: got %h required %h", i, {halted, instr_valid, rom_addr}, {1'b1, 1'b0, 8'h00});
      end
    end
    redirect_en = 0;
    reset = 1;
    @(negedge clk);
    n_chk++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: got %b required 0", halted);
    end
    reset = 0;
`else
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({halted, instr_valid, obs} !== {1'b0, 1'b1, 24'hFF_40_00}) begin
      n_fail++;
      $display("FAIL blank_jc: got %h required %h", {halted, instr_valid, obs}, {1'b0, 1'b1, 24'hFF_40_00});
    end
`endif
  endtask

  task automatic test_random();
    ins_t e, held;
    bit hold = 0, r, rd;
    logic [7:0] ra;
    for (int i = 0; i < 256; i++)
`ifdef FETCH_HALT_ON_BLANK_EN
      rom[i] = 8'($urandom_range(0, 254));
`else
      rom[i] = 8'($urandom_range(0, 255));
`endif
    instr_ready = 0;
    do_reset();
    q.delete();
    mpc = 8'h00;
    mhalt = 0;
    refill();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hold) begin
        n_chk++;
        if ({instr_valid, obs} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL rand_stable c%0d: got %h required %h", c, {instr_valid, obs}, {1'b1, held});
        end
      end
      r = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 15) == 0;
      ra = 8'($urandom);
      if (instr_valid && r) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_issue c%0d: got %h required none", c, obs);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL rand_issue c%0d: got %h required %h", c, obs, e);
          end
        end
        refill();
      end
      hold = instr_valid && !r && !rd;
      held = obs;
      if (rd) begin
        q.delete();
        mpc = ra;
        refill();
      end
      instr_ready = r;
      redirect_en = rd;
      redirect_addr = ra;
    end
    @(negedge clk);
    instr_ready = 0;
    redirect_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_jmp();
    test_jc_redirect();
    test_wrap_reset();
    test_blank();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
